// File: rtl/reg_write_arbiter_pkg.sv
// rtl/reg_write_arbiter_pkg.sv - state type, default sizes and pointer helper for reg_write_arbiter
package reg_arb_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WRITE        = 3'd1,
    ACK          = 3'd2,
    CLEAR        = 3'd3,
    CLR_ACK      = 3'd4,
    WRITE_LOCKED = 3'd5
  } state_e;

  function automatic int unsigned next_rr_ptr(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - requester/dff bundle for reg_write_arbiter (lock signal under REG_ARB_LOCK_EN)
interface reg_write_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = $clog2(N_REQ)
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic                   clr_req;
`ifdef REG_ARB_LOCK_EN
  logic [N_REQ-1:0]       lock;
`endif
  logic [N_REQ-1:0]       ack;
  logic                   clr_ack;
  logic [WIDTH-1:0]       dff_en;
  logic [WIDTH-1:0]       dff_rst;
  logic [WIDTH-1:0]       dff_d;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   busy;

`ifdef REG_ARB_LOCK_EN
  modport master (
    output req, wdata, clr_req, lock,
    input  ack, clr_ack, dff_en, dff_rst, dff_d, gnt_idx, busy
  );
  modport slave (
    input  req, wdata, clr_req, lock,
    output ack, clr_ack, dff_en, dff_rst, dff_d, gnt_idx, busy
  );
`else
  modport master (
    output req, wdata, clr_req,
    input  ack, clr_ack, dff_en, dff_rst, dff_d, gnt_idx, busy
  );
  modport slave (
    input  req, wdata, clr_req,
    output ack, clr_ack, dff_en, dff_rst, dff_d, gnt_idx, busy
  );
`endif

endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// rtl/reg_write_arbiter_rr_pick.sv - combinational round-robin picker: first set req at or above rr_ptr, wrapping
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  always_comb begin
    // rotate so rr_ptr sits at bit 0; lowest set bit is the distance to the winner
    rot = N_REQ'({req, req} >> rr_ptr);
    off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = IDX_W'(k);
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
    winner  = sum[IDX_W-1:0];
    any_req = |req;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin write arbiter sequencing a shared dff; REG_ARB_LOCK_EN adds locked back-to-back writes
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input logic           clk,
  input logic           nreset,
  reg_write_arbiter_if.slave bus
);

  state_e           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic [WIDTH-1:0] win_data;
  logic [N_REQ-1:0] ack_vec;
`ifdef REG_ARB_LOCK_EN
  logic [WIDTH-1:0] gnt_data;
  logic             lock_win;
`endif

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req     (bus.req),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    win_data = '0;
    ack_vec  = '0;
`ifdef REG_ARB_LOCK_EN
    gnt_data = '0;
    lock_win = 1'b0;
`endif
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == IDX_W'(i)) win_data = bus.wdata[i*WIDTH +: WIDTH];
      if (bus.gnt_idx == IDX_W'(i)) begin
        ack_vec[i] = 1'b1;
`ifdef REG_ARB_LOCK_EN
        gnt_data   = bus.wdata[i*WIDTH +: WIDTH];
        lock_win   = bus.lock[i];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      bus.ack     <= '0;
      bus.clr_ack <= 1'b0;
      bus.dff_en  <= '0;
      bus.dff_rst <= '0;
      bus.dff_d   <= '0;
      bus.gnt_idx <= '0;
      bus.busy    <= 1'b0;
    end else begin
      // strobes default low so each lasts exactly one cycle
      bus.ack     <= '0;
      bus.clr_ack <= 1'b0;
      bus.dff_en  <= '0;
      bus.dff_rst <= '0;
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state       <= CLEAR;
            bus.dff_rst <= '1;
            bus.busy    <= 1'b1;
          end else if (any_req) begin
            state       <= WRITE;
            bus.gnt_idx <= winner;
            bus.dff_d   <= win_data;
            bus.dff_en  <= '1;
            bus.busy    <= 1'b1;
          end
        end
        WRITE, WRITE_LOCKED: begin
          state   <= ACK;
          bus.ack <= ack_vec;
        end
        ACK: begin
`ifdef REG_ARB_LOCK_EN
          if (lock_win && !bus.clr_req) begin
            state      <= WRITE_LOCKED;
            bus.dff_d  <= gnt_data;
            bus.dff_en <= '1;
          end else begin
            state    <= IDLE;
            rr_ptr   <= IDX_W'(next_rr_ptr(32'(bus.gnt_idx), N_REQ));
            bus.busy <= 1'b0;
          end
`else
          state    <= IDLE;
          rr_ptr   <= IDX_W'(next_rr_ptr(32'(bus.gnt_idx), N_REQ));
          bus.busy <= 1'b0;
`endif
        end
        CLEAR: begin
          state       <= CLR_ACK;
          bus.clr_ack <= 1'b1;
        end
        CLR_ACK: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - scoreboard bench for reg_write_arbiter with a behavioural dff model
module tb_reg_write_arbiter;

  localparam int NR = 4;
  localparam int W  = 32;
  localparam int K_WR = 0, K_ACK = 1, K_CLR = 2, K_CA = 3;

  logic clk = 1'b0;
  logic nreset;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  typedef struct {
    int          kind;
    int          cyc;
    int          idx;
    logic [31:0] data;
  } ev_t;

  ev_t         sbq[$];
  logic [31:0] wv[NR];
  logic [W-1:0] q;

  reg_write_arbiter_if #(.N_REQ(NR), .WIDTH(W)) bus ();

  reg_write_arbiter #(.N_REQ(NR), .WIDTH(W)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // shared register model driven by the arbiter's enable/reset/D outputs
  always @(posedge clk) begin
    for (int i = 0; i < W; i++) begin
      if (bus.dff_rst[i]) q[i] <= 1'b0;
      else if (bus.dff_en[i]) q[i] <= bus.dff_d[i];
    end
  end

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push(int kind, int c, int idx, logic [31:0] d);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.idx  = idx;
    e.data = d;
    sbq.push_back(e);
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic setw(int i, logic [31:0] v);
    bus.wdata[i*W +: W] = v;
  endtask

  always @(negedge clk) begin
    if (|bus.dff_en || |bus.dff_rst || |bus.ack || bus.clr_ack) begin
      int  k;
      ev_t e;
      if (|bus.dff_en) k = K_WR;
      else if (|bus.ack) k = K_ACK;
      else if (|bus.dff_rst) k = K_CLR;
      else k = K_CA;
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", k, cyc);
      end else begin
        e = sbq.pop_front();
        check("event_kind", k, e.kind);
        check("event_cycle", cyc, e.cyc);
        check("en_rst_exclusive", |(bus.dff_en & bus.dff_rst), 0);
        case (e.kind)
          K_WR: begin
            check("dff_en", bus.dff_en, 32'hFFFF_FFFF);
            check("gnt_idx", bus.gnt_idx, e.idx);
            check("dff_d", bus.dff_d, e.data);
          end
          K_ACK: begin
            check("ack", bus.ack, 1 << e.idx);
            check("q_after_write", q, e.data);
          end
          K_CLR: check("dff_rst", bus.dff_rst, 32'hFFFF_FFFF);
          default: check("q_after_clear", q, 0);
        endcase
      end
    end
  end

`ifdef REG_ARB_LOCK_EN
  initial bus.lock = '0;
`endif

  initial begin
    int c;
    wv[0] = 32'h0000_A0A0;
    wv[1] = 32'h1111_B1B1;
    wv[2] = 32'h2222_C2C2;
    wv[3] = 32'h3333_D3D3;
    nreset      = 1'b1;
    bus.req     = '0;
    bus.clr_req = 1'b0;
    for (int i = 0; i < NR; i++) setw(i, wv[i]);
    #1 nreset = 1'b0;
    bus.req = 4'b1111;
    repeat (3) step();
    check("rst_ack", bus.ack, 0);
    check("rst_clr_ack", bus.clr_ack, 0);
    check("rst_dff_en", bus.dff_en, 0);
    check("rst_dff_rst", bus.dff_rst, 0);
    check("rst_dff_d", bus.dff_d, 0);
    check("rst_gnt_idx", bus.gnt_idx, 0);
    check("rst_busy", bus.busy, 0);

    // release with all requesters active: grants rotate 0,1,2,3,0
    step(); c = cyc; nreset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push(K_WR,  c + 1 + 3*k, k % NR, wv[k % NR]);
      push(K_ACK, c + 2 + 3*k, k % NR, wv[k % NR]);
    end
    repeat (14) step();
    bus.req = '0;
    step();

    // single writer; wdata change after grant is ignored
    step(); c = cyc; bus.req = 4'b0100; setw(2, 32'hDEAD_BEEF);
    push(K_WR,  c + 1, 2, 32'hDEAD_BEEF);
    push(K_ACK, c + 2, 2, 32'hDEAD_BEEF);
    step(); setw(2, 32'h0); check("busy_in_write", bus.busy, 1);
    step(); bus.req = '0;
    step();

    // clear beats simultaneous reqs; rr_ptr=3 wraps to requester 0
    step(); c = cyc; bus.clr_req = 1'b1; bus.req = 4'b0011;
    push(K_CLR, c + 1, 0, 32'h0);
    push(K_CA,  c + 2, 0, 32'h0);
    push(K_WR,  c + 4, 0, wv[0]);
    push(K_ACK, c + 5, 0, wv[0]);
    push(K_WR,  c + 7, 1, wv[1]);
    push(K_ACK, c + 8, 1, wv[1]);
    step(); bus.clr_req = 1'b0;
    step();
    step(); check("q_zero_after_clear", q, 0); check("busy_idle", bus.busy, 0);
    step();
    step(); bus.req = 4'b0010;
    repeat (3) step();
    bus.req = '0;
    step();

    // clr_req raised during WRITE waits for the next IDLE
    step(); c = cyc; bus.req = 4'b1000;
    push(K_WR,  c + 1, 3, wv[3]);
    push(K_ACK, c + 2, 3, wv[3]);
    push(K_CLR, c + 4, 0, 32'h0);
    push(K_CA,  c + 5, 0, 32'h0);
    step(); bus.clr_req = 1'b1;
    step(); bus.req = '0;
    step();
    step(); bus.clr_req = 1'b0;
    step();
    step();

    // move rr_ptr to 1, then reset during WRITE
    step(); c = cyc; bus.req = 4'b0001;
    push(K_WR,  c + 1, 0, wv[0]);
    push(K_ACK, c + 2, 0, wv[0]);
    step();
    step(); bus.req = '0;
    step(); c = cyc; bus.req = 4'b0100; setw(2, 32'hCAFE_F00D);
    push(K_WR, c + 1, 2, 32'hCAFE_F00D);
    step();
    #1 nreset = 1'b0;
    #1;
    check("midop_dff_en", bus.dff_en, 0);
    check("midop_ack", bus.ack, 0);
    check("midop_busy", bus.busy, 0);
    check("midop_dff_d", bus.dff_d, 0);
    bus.req = '0;
    step();
    step();
    // rr_ptr back at 0 picks requester 0 out of 4'b1001
    step(); c = cyc; nreset = 1'b1; bus.req = 4'b1001;
    push(K_WR,  c + 1, 0, wv[0]);
    push(K_ACK, c + 2, 0, wv[0]);
    step();
    step(); bus.req = '0;
    repeat (4) step();

    check("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares one n-bit dff register between N_REQ requesters; only one write lands per access.
- Uses round-robin arbitration with a req/ack handshake.
- Sequences the register's enable, reset and D inputs through a small FSM.
- Sits between the datapath writers (ALU result, load path, debug port, etc.) and the shared dff instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 32, register width; matches the dff parameter n.
- IDX_W, $clog2(N_REQ), width of the grant index.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- nreset  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-requester write request; held high until ack.
- wdata  input  N_REQ*WIDTH  packed write data; slice i belongs to requester i.
- clr_req  input  1  request to clear the register to zero.
- ack  output  N_REQ  one-hot, one-cycle write acknowledge.
- clr_ack  output  1  one-cycle clear acknowledge.
- dff_en  output  WIDTH  per-bit enable to the dff (all bits equal).
- dff_rst  output  WIDTH  per-bit reset to the dff (all bits equal, active-high).
- dff_d  output  WIDTH  data to the dff D input.
- gnt_idx  output  IDX_W  index of the current or last winner.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (nreset=0, asynchronous):
  - state=IDLE, rr_ptr=0.
  - ack=0, clr_ack=0, dff_en=0, dff_rst=0, dff_d=0, gnt_idx=0, busy=0.
- FSM states are IDLE, WRITE, ACK, CLEAR, CLR_ACK. All outputs are registered.
- IDLE:
  - If clr_req=1 -> CLEAR. Clear beats any req.
  - Else if req!=0, choose the winner: the first set bit at or after rr_ptr, searching upward and wrapping modulo N_REQ.
  - On a win: latch gnt_idx and dff_d=wdata[winner] -> WRITE.
  - Else stay in IDLE.
- WRITE: dff_en=all ones for exactly one cycle -> ACK.
- ACK:
  - ack[gnt_idx]=1 for one cycle; dff_en=0.
  - rr_ptr = (gnt_idx+1) mod N_REQ -> IDLE.
- CLEAR: dff_rst=all ones, dff_en=0 for one cycle -> CLR_ACK.
- CLR_ACK: clr_ack=1 for one cycle; rr_ptr unchanged -> IDLE.
- Latency:
  - req first seen in IDLE at cycle t: WRITE at t+1, ack at t+2, next arbitration at t+3.
  - Maximum throughput is one write per 3 cycles.
- wdata is sampled only in IDLE at the grant edge. Later changes to it are ignored.
- A req that drops after the grant does not abort the write; the write and ack still complete.
- A clr_req that arrives during WRITE or ACK waits. It is serviced from the next IDLE, ahead of pending reqs.
- A single requester with req held high is re-granted every 3 cycles. With all requesters active, grants rotate 0,1,2,3,0,...
- When rr_ptr = N_REQ-1, the search wraps to 0.
- Reset asserted mid-operation abandons the transaction immediately: no ack, and dff_en drops asynchronously.
- dff_en and dff_rst are never high in the same cycle.
- Requesters must drop req in the cycle after ack. If req is still high, it is treated as a new request.

Optional Feature:
- Macro: REG_ARB_LOCK_EN.
- With the macro defined:
  - Adds input lock [N_REQ].
  - If the winner holds lock high during ACK, the FSM goes ACK -> WRITE_LOCKED. In this state it latches the winner's fresh wdata and re-grants the same index without arbitration.
  - Locked throughput is one write per 2 cycles.
  - clr_req still preempts at the next ACK exit.
  - rr_ptr advances only when the lock is released.
- Without the macro: no lock port and no WRITE_LOCKED state; behaviour is as described above.

Decomposition:
- Package reg_arb_pkg holds:
  - the state enum (IDLE, WRITE, ACK, CLEAR, CLR_ACK, WRITE_LOCKED);
  - the default N_REQ and WIDTH localparams;
  - the function next_rr_ptr.
- One sub-module: rr_pick, a combinational round-robin priority picker.
  - Inputs: req, rr_ptr. Outputs: winner index, any_req.
  - Reusable by other arbiters.
- The FSM and output registers stay in reg_write_arbiter.

Test Plan:
- Reset: hold nreset=0 for 3 cycles with req=4'b1111 -> all outputs 0. After release, first grant is idx 0, ack=4'b0001 at t+2.
- Single writer: req=4'b0100, wdata[2]=32'hDEADBEEF -> dff_en all ones for one cycle at t+1. Register Q reads 32'hDEADBEEF. ack=4'b0100 at t+2.
- Fairness: req=4'b1111 held high with acks consumed -> grant order 0,1,2,3,0 at 3-cycle spacing. No index is granted twice before all have been served.
- Clear priority: clr_req=1 and req=4'b0011 in the same IDLE cycle -> dff_rst all ones at t+1, clr_ack at t+2. Then requester 0 is written at t+4 with its ack at t+5. Q=0 between the clear and that write.
- Reset mid-op: drop nreset during WRITE -> dff_en=0 immediately, no ack. After release, state=IDLE and rr_ptr=0.
- Lock (REG_ARB_LOCK_EN): requester 1 writes 0x1, 0x2, 0x3 with lock=1 while req=4'b0011 -> requester 1 writes at 2-cycle spacing. Requester 0 is granted only after lock drops.
